// File: rtl/ctrl_disp_pkg.sv
// Shared glyphs, label ROM and state encodings for the controller label marquee.
package ctrl_disp_pkg;

  localparam int MAX_LABEL_LEN = 4;
  localparam int LEN_W         = 3;
  localparam int BLINK_PHASES  = 6;

  localparam logic [6:0] GLYPH_N     = 7'b100_1000;
  localparam logic [6:0] GLYPH_E     = 7'b000_0110;
  localparam logic [6:0] GLYPH_S     = 7'b001_0010;
  localparam logic [6:0] GLYPH_G     = 7'b100_0010;
  localparam logic [6:0] GLYPH_A     = 7'b000_1000;
  localparam logic [6:0] GLYPH_BLANK = 7'b111_1111;

  typedef enum logic [1:0] {
    SEL_NES  = 2'b00,
    SEL_SNES = 2'b01,
    SEL_SEGA = 2'b10,
    SEL_NONE = 2'b11
  } ctrl_sel_t;

  typedef enum logic [1:0] {
    ST_STEADY = 2'b00,
    ST_BLINK  = 2'b01,
    ST_SCROLL = 2'b10
  } disp_state_t;

  // chars[0] is the first character of the label
  typedef struct packed {
    logic [LEN_W-1:0]                len;
    logic [MAX_LABEL_LEN-1:0][6:0]   chars;
  } label_t;

  localparam label_t LABEL_NES  = {3'd3, GLYPH_BLANK, GLYPH_S, GLYPH_E, GLYPH_N};
  localparam label_t LABEL_SNES = {3'd4, GLYPH_S, GLYPH_E, GLYPH_N, GLYPH_S};
  localparam label_t LABEL_SEGA = {3'd4, GLYPH_A, GLYPH_G, GLYPH_E, GLYPH_S};
  localparam label_t LABEL_NONE = {3'd0, GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK};

  function automatic label_t label_rom(input ctrl_sel_t s);
    label_t l;
    case (s)
      SEL_NES:  l = LABEL_NES;
      SEL_SNES: l = LABEL_SNES;
      SEL_SEGA: l = LABEL_SEGA;
      SEL_NONE: l = LABEL_NONE;
      default:  l = LABEL_NONE;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_CYCLES clocks, restartable by clr.
module tick_gen #(
  parameter int TICK_CYCLES = 12_500_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // cycle counter, wraps at CNT_LAST or restarts on clr
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr || (cnt_r == CNT_LAST)) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign tick = (cnt_r == CNT_LAST) && !clr;

endmodule

// File: rtl/controller_label_marquee.sv
// Shows the selected controller name on a 7-segment row: blinks on change,
// then holds steady or scrolls it as a marquee.
module controller_label_marquee
  import ctrl_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int TICK_CYCLES = 12_500_000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [1:0]                 sel,
  input  logic                       scroll_en,
  output logic [NUM_DIGITS-1:0][6:0] seg,
  output logic                       blinking
);

  localparam int P_MAX  = MAX_LABEL_LEN + NUM_DIGITS;
  localparam int OFF_W  = $clog2(P_MAX);
  localparam int PH_W   = $clog2(BLINK_PHASES);
  localparam int IDX_W  = $clog2(2 * P_MAX);
  localparam int CHR_W  = $clog2(MAX_LABEL_LEN);
  localparam logic [PH_W-1:0] PHASE_LAST = 3'd5;

  ctrl_sel_t                           sel_q_r;
  disp_state_t                         state_r;
  logic [OFF_W-1:0]                    offset_r;
  logic [PH_W-1:0]                     phase_r;
  logic [NUM_DIGITS-1:0][6:0]          seg_r;

  logic                                tick_s;
  logic                                sel_chg_s;
  label_t                              label_s;
  logic [IDX_W-1:0]                    plen_s;
  logic [OFF_W-1:0]                    show_off_s;
  logic                                show_s;
  logic [NUM_DIGITS-1:0][IDX_W-1:0]    idx_s;
  logic [NUM_DIGITS-1:0][6:0]          seg_next_s;

  assign sel_chg_s = (ctrl_sel_t'(sel) != sel_q_r);
  assign label_s   = label_rom(sel_q_r);
  assign plen_s    = IDX_W'(label_s.len) + IDX_W'(NUM_DIGITS);

  tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (sel_chg_s),
    .tick    (tick_s)
  );

  // display FSM; a selector change overrides every other transition
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q_r  <= SEL_NONE;
      state_r  <= ST_STEADY;
      offset_r <= {OFF_W{1'b0}};
      phase_r  <= {PH_W{1'b0}};
    end else begin
      sel_q_r <= ctrl_sel_t'(sel);
      if (sel_chg_s) begin
        state_r  <= ST_BLINK;
        offset_r <= {OFF_W{1'b0}};
        phase_r  <= {PH_W{1'b0}};
      end else begin
        case (state_r)
          ST_STEADY: begin
            offset_r <= {OFF_W{1'b0}};
            if (scroll_en) begin
              state_r <= ST_SCROLL;
            end
          end
          ST_BLINK: begin
            offset_r <= {OFF_W{1'b0}};
            if (tick_s) begin
              if (phase_r == PHASE_LAST) begin
                phase_r <= {PH_W{1'b0}};
                state_r <= scroll_en ? ST_SCROLL : ST_STEADY;
              end else begin
                phase_r <= phase_r + 1'b1;
              end
            end
          end
          ST_SCROLL: begin
            if (!scroll_en) begin
              state_r  <= ST_STEADY;
              offset_r <= {OFF_W{1'b0}};
            end else if (tick_s) begin
              if (IDX_W'(offset_r) == (plen_s - 1'b1)) begin
                offset_r <= {OFF_W{1'b0}};
              end else begin
                offset_r <= offset_r + 1'b1;
              end
            end
          end
          default: begin
            state_r  <= ST_STEADY;
            offset_r <= {OFF_W{1'b0}};
            phase_r  <= {PH_W{1'b0}};
          end
        endcase
      end
    end
  end

  // window into the label-plus-blanks string; sum stays below 2*P so one subtract wraps it
  always_comb begin
    seg_next_s = {NUM_DIGITS{GLYPH_BLANK}};
    idx_s      = {(NUM_DIGITS*IDX_W){1'b0}};
    show_off_s = {OFF_W{1'b0}};
    show_s     = 1'b0;
    case (state_r)
      ST_STEADY: show_s = 1'b1;
      ST_BLINK:  show_s = phase_r[0];
      ST_SCROLL: begin
        show_s     = 1'b1;
        show_off_s = offset_r;
      end
      default:   show_s = 1'b0;
    endcase
    for (int i = 0; i < NUM_DIGITS; i++) begin
      idx_s[i] = IDX_W'(show_off_s) + IDX_W'(i);
      if (idx_s[i] >= plen_s) begin
        idx_s[i] = idx_s[i] - plen_s;
      end else begin
        idx_s[i] = idx_s[i];
      end
      if (show_s && (idx_s[i] < IDX_W'(label_s.len))) begin
        seg_next_s[i] = label_s.chars[idx_s[i][CHR_W-1:0]];
      end else begin
        seg_next_s[i] = GLYPH_BLANK;
      end
    end
  end

  // segment output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_r <= {NUM_DIGITS{GLYPH_BLANK}};
    end else begin
      seg_r <= seg_next_s;
    end
  end

  assign seg      = seg_r;
  assign blinking = (state_r == ST_BLINK);

endmodule

// File: tb/tb_controller_label_marquee.sv
// Scoreboard bench: stimulus queues expected (cycle, seg, blinking); a negedge monitor pops and compares.
module tb_controller_label_marquee;

  logic             clk;
  logic             reset_n;
  logic [1:0]       sel;
  logic             scroll_en;
  logic [5:0][6:0]  seg;
  logic             blinking;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  int          cyc_q[$];
  logic [41:0] seg_q[$];
  logic        blk_q[$];
  string       name_q[$];

  localparam logic [6:0] GN = 7'b1001000;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GS = 7'b0010010;
  localparam logic [6:0] GG = 7'b1000010;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GB = 7'b1111111;

  controller_label_marquee #(
    .NUM_DIGITS  (6),
    .TICK_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sel       (sel),
    .scroll_en (scroll_en),
    .seg       (seg),
    .blinking  (blinking)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [41:0] w(input logic [6:0] d0, input logic [6:0] d1, input logic [6:0] d2,
                                    input logic [6:0] d3, input logic [6:0] d4, input logic [6:0] d5);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic expect_at(input int c, input logic [41:0] s, input logic b, input string nm);
    cyc_q.push_back(c);
    seg_q.push_back(s);
    blk_q.push_back(b);
    name_q.push_back(nm);
  endtask

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor: compare every queued expectation in the cycle it is due
  initial begin
    int          c;
    logic [41:0] s;
    logic        b;
    string       nm;
    forever begin
      @(negedge clk);
      while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
        c  = cyc_q.pop_front();
        s  = seg_q.pop_front();
        b  = blk_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (c != cyc) begin
          failures++;
          $display("FAIL %s: not sampled at due cycle %0d (now %0d)", nm, c, cyc);
        end else if (seg !== s || blinking !== b) begin
          failures++;
          $display("FAIL %s cycle %0d: seg=%h blinking=%b expected seg=%h blinking=%b",
                   nm, cyc, seg, blinking, s, b);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [41:0] blank6, nes, snes, sega;
    blank6 = w(GB, GB, GB, GB, GB, GB);
    nes    = w(GN, GE, GS, GB, GB, GB);
    snes   = w(GS, GN, GE, GS, GB, GB);
    sega   = w(GS, GE, GG, GA, GB, GB);

    reset_n   = 1'b0;
    sel       = 2'b00;
    scroll_en = 1'b0;

    expect_at(2, blank6, 1'b0, "reset_state");
    step_to(2);
    reset_n = 1'b1;

    // NES blink: three blank/label pairs of 4 cycles, then steady
    expect_at(3,  blank6, 1'b1, "blink_enter");
    expect_at(7,  blank6, 1'b1, "blink_ph0_end");
    expect_at(8,  nes,    1'b1, "blink_ph1");
    expect_at(11, nes,    1'b1, "blink_ph1_end");
    expect_at(12, blank6, 1'b1, "blink_ph2");
    expect_at(16, nes,    1'b1, "blink_ph3");
    expect_at(20, blank6, 1'b1, "blink_ph4");
    expect_at(24, nes,    1'b1, "blink_ph5");
    expect_at(26, nes,    1'b1, "blink_ph5_end");
    expect_at(27, nes,    1'b0, "steady_enter");
    expect_at(30, nes,    1'b0, "steady_nes");
    step_to(30);
    sel = 2'b01;

    expect_at(31, nes,  1'b1, "snes_change");
    expect_at(36, snes, 1'b1, "snes_blink_ph1");
    expect_at(56, snes, 1'b0, "snes_steady");
    step_to(56);
    scroll_en = 1'b1;

    expect_at(60, w(GN, GE, GS, GB, GB, GB), 1'b0, "scroll_off1");
    expect_at(84, w(GB, GB, GB, GS, GN, GE), 1'b0, "scroll_off7");
    expect_at(95, w(GB, GS, GN, GE, GS, GB), 1'b0, "scroll_off9");
    expect_at(96, snes, 1'b0, "scroll_wrap0");
    step_to(96);
    sel = 2'b10;

    expect_at(97,  snes,   1'b1, "sega_change");
    expect_at(98,  blank6, 1'b1, "sega_blank");
    expect_at(102, sega,   1'b1, "sega_blink_ph1");
    expect_at(121, sega,   1'b0, "sega_scroll_enter");
    expect_at(126, w(GE, GG, GA, GB, GB, GB), 1'b0, "sega_off1");
    expect_at(142, w(GB, GB, GB, GB, GB, GS), 1'b0, "sega_off5");
    step_to(142);
    scroll_en = 1'b0;

    expect_at(143, w(GB, GB, GB, GB, GB, GS), 1'b0, "drop_lag");
    expect_at(144, sega, 1'b0, "drop_steady");
    step_to(145);
    sel = 2'b00;

    expect_at(151, nes,    1'b1, "nes_blink_ph1");
    expect_at(152, blank6, 1'b0, "reset_async");
    step_to(152);
    reset_n = 1'b0;

    expect_at(154, blank6, 1'b0, "reset_hold");
    step_to(154);
    reset_n = 1'b1;

    expect_at(155, blank6, 1'b1, "post_reset_blink");
    expect_at(159, blank6, 1'b1, "post_reset_ph0_end");
    expect_at(160, nes,    1'b1, "post_reset_ph1");
    step_to(160);
    sel       = 2'b11;
    scroll_en = 1'b1;

    expect_at(161, nes, 1'b1, "none_change");
    for (int c = 162; c <= 265; c++) begin
      expect_at(c, blank6, (c <= 184), "none_blank");
    end
    step_to(268);

    if (cyc_q.size() != 0) begin
      failures += cyc_q.size();
      $display("FAIL leftover: %0d expectations never checked, expected 0", cyc_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controller_label_marquee.md
CONTROLLER_LABEL_MARQUEE -- requirements
Module: controller_label_marquee

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6: number of 7-segment digits driven; legal range is 4 or more.
REQ-002 SHALL have parameter TICK_CYCLES, default 12_500_000: clk cycles per display step; legal range is 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sel, input, 2 bits: controller type. 00=NES, 01=SNES, 10=SEGA, 11=none.
REQ-006 SHALL have port scroll_en, input, 1 bit: 1 requests marquee scrolling.
REQ-007 SHALL have port seg, output, NUM_DIGITS x 7 bits (packed): per-digit active-low {g,f,e,d,c,b,a}; seg[0] shows the first character.
REQ-008 SHALL have port blinking, output, 1 bit: high while in BLINK state.

Function
REQ-009 Glyphs SHALL be: N=100_1000, E=000_0110, S=001_0010, G=100_0010, A=000_1000, blank=111_1111.
REQ-010 Labels SHALL be: 00 -> "NES" (len 3); 01 -> "SNES" (len 4); 10 -> "SEGA" (len 4); 11 -> empty (len 0).
REQ-011 The virtual string SHALL be the label followed by NUM_DIGITS blanks, length P = len + NUM_DIGITS; digit i SHALL show char[(offset+i) mod P].
REQ-012 Tick SHALL be a 1-cycle pulse every TICK_CYCLES cycles; the tick counter SHALL clear to 0 on a sel change.
REQ-013 sel SHALL be registered into sel_q every cycle; a sel change SHALL be detected when sel != sel_q.
REQ-014 FSM states SHALL be STEADY, BLINK and SCROLL.
REQ-015 Any state, on a sel change: SHALL go to BLINK with phase=0 and offset=0; this has priority over all other transitions.
REQ-016 In BLINK, phase SHALL increment on each tick; after the tick at phase 5, SHALL go to SCROLL if scroll_en is 1, else STEADY.
REQ-017 In BLINK, display SHALL be all blank when phase is even and the label at offset 0 when phase is odd.
REQ-018 In STEADY, offset SHALL be 0; if scroll_en is 1, SHALL go to SCROLL.
REQ-019 In SCROLL, offset SHALL increment on each tick and wrap from P-1 to 0.
REQ-020 In SCROLL, if scroll_en is 0, SHALL go to STEADY with offset=0 on the next edge.
REQ-021 seg SHALL be registered: it reflects state/offset/phase one cycle after they update.
REQ-022 blinking SHALL be asserted combinationally from state == BLINK.
REQ-023 sel=11 SHALL yield all-blank seg in every state; its FSM sequencing SHALL be unchanged.
REQ-024 Offset and phase widths SHALL be $clog2 of their ranges; no arithmetic SHALL overflow for any legal parameter value.

Reset
REQ-025 On reset_n low, SHALL immediately set: state=STEADY, offset=0, phase=0, tick counter=0, sel_q=11, every seg digit=111_1111.
REQ-026 After release, any sel other than 11 SHALL trigger BLINK as a sel change.
REQ-027 Reset asserted mid-BLINK or mid-SCROLL SHALL abort the operation with no residual state.

Structure
REQ-028 Package ctrl_disp_pkg SHALL hold the glyph constants, the ctrl_sel_t enum, the label ROM typedef/constant with lengths, MAX_LABEL_LEN=4 and the FSM state enum.
REQ-029 The tick prescaler SHALL be sub-module tick_gen, with parameter TICK_CYCLES and inputs clk, reset_n, clr; it SHALL output tick.

Verification (NUM_DIGITS=6, TICK_CYCLES=4)
REQ-030 Reset release with sel=00, scroll_en=0: blinking=1 with alternating blank / N,E,S phases, each 4 cycles, 3 pairs; then STEADY with seg = N,E,S,blank,blank,blank and blinking=0.
REQ-031 sel=01 steady, then scroll_en=1: at offset 1, seg = N,E,S,blank,blank,blank; at offset 7, seg = blank,blank,blank,S,N,E; after 10 ticks, offset returns to 0.
REQ-032 sel changed 01->10 mid-SCROLL: next cycle, blinking=1 and offset=0; after 6 ticks, SCROLL resumes with S,E,G,A.
REQ-033 scroll_en dropped at offset 5: state is STEADY with offset 0 next edge; seg shows the label one cycle later.
REQ-034 reset_n pulsed low mid-BLINK: all seg = 111_1111 asynchronously, blinking=0.
REQ-035 sel=11 with scroll_en=1 for 20 ticks: all seg stay 111_1111.
